// File: rtl/subleq_pkg.sv
// subleq_pkg: shared types and constants for the SUBLEQ core.
//   subleq_state_t : FSM state encoding for subleq_core
//   INSTR_LEN      : words per instruction (a, b, c)
//   DEF_*          : default parameter values for subleq_core
package subleq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    FETCH_C,
    READ_A,
    READ_B,
    WRITE_B,
    HALT
  } subleq_state_t;

  localparam int INSTR_LEN      = 3;
  localparam int DEF_DW         = 8;
  localparam int DEF_AW         = 8;
  localparam int DEF_START_ADDR = 0;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/subleq_alu.sv
// subleq_alu: combinational SUBLEQ subtract-and-test.
//   a    (in,  DW) : subtrahend, mem[a]
//   b    (in,  DW) : minuend, mem[b]
//   diff (out, DW) : b - a, two's complement, wrapping
//   leq  (out, 1)  : diff <= 0, judged on the wrapped result
module subleq_alu #(
  parameter int DW = 8
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] diff,
  output logic                 leq
);

  assign diff = b - a;
  // Sign bit of the wrapped result: overflow is deliberately not corrected.
  assign leq  = diff[DW-1] | (diff == '0);

endmodule

// File: rtl/subleq_core.sv
// subleq_core: multi-cycle SUBLEQ processor with a req/ack memory port.
//   clk, res (sync, active-low)  : clock and reset
//   start                        : begin execution at START_ADDR (IDLE/HALT only)
//   mem_req/we/addr/wdata        : registered memory request, held until mem_ack
//   mem_rdata, mem_ack           : read data and access completion
//   busy, halted                 : status
//   pc, instr_cnt                : program counter, saturating instruction count
module subleq_core
  import subleq_pkg::*;
#(
  parameter int             DW         = DEF_DW,
  parameter int             AW         = DEF_AW,
  parameter logic [AW-1:0]  START_ADDR = AW'(DEF_START_ADDR),
  parameter logic [AW-1:0]  HALT_ADDR  = {AW{1'b1}},
  parameter int             CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic             halted,
  output logic [AW-1:0]    pc,
  output logic [CNT_W-1:0] instr_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  subleq_state_t     state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [AW-1:0]     a_addr_q, a_addr_d;
  logic [AW-1:0]     b_addr_q, b_addr_d;
  logic [AW-1:0]     c_q, c_d;
  logic [DW-1:0]     a_val_q, a_val_d;
  logic              leq_q, leq_d;

  logic signed [DW-1:0] alu_diff;
  logic                 alu_leq;
  logic                 ack;

  // An ack with no request outstanding is meaningless and ignored.
  assign ack = mem_ack & req_q;

  // B value is taken straight from the read port in the READ_B ack cycle.
  subleq_alu #(.DW(DW)) u_alu (
    .a    (a_val_q),
    .b    (mem_rdata),
    .diff (alu_diff),
    .leq  (alu_leq)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    c_d      = c_q;
    a_val_d  = a_val_q;
    leq_d    = leq_q;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = FETCH_A;
          pc_d    = START_ADDR;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = START_ADDR;
        end
      end
      FETCH_A: if (ack) begin
        a_addr_d = mem_rdata[AW-1:0];
        addr_d   = pc_q + AW'(1);
        state_d  = FETCH_B;
      end
      FETCH_B: if (ack) begin
        b_addr_d = mem_rdata[AW-1:0];
        addr_d   = pc_q + AW'(2);
        state_d  = FETCH_C;
      end
      FETCH_C: if (ack) begin
        c_d     = mem_rdata[AW-1:0];
        addr_d  = a_addr_q;
        state_d = READ_A;
      end
      READ_A: if (ack) begin
        a_val_d = mem_rdata;
        addr_d  = b_addr_q;
        state_d = READ_B;
      end
      READ_B: if (ack) begin
        wdata_d = alu_diff;
        leq_d   = alu_leq;
        we_d    = 1'b1;
        state_d = WRITE_B;
      end
      WRITE_B: if (ack) begin
        cnt_d = sat_inc(cnt_q);
        we_d  = 1'b0;
        // A halting branch leaves pc on the halting instruction.
        if (leq_q && (c_q == HALT_ADDR)) begin
          req_d   = 1'b0;
          state_d = HALT;
        end else begin
          pc_d    = leq_q ? c_q : pc_q + AW'(INSTR_LEN);
          addr_d  = pc_d;
          state_d = FETCH_A;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    a_addr_q <= a_addr_d;
    b_addr_q <= b_addr_d;
    c_q      <= c_d;
    a_val_q  <= a_val_d;
    leq_q    <= leq_d;
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = !(state_q inside {IDLE, HALT});
  assign halted    = (state_q == HALT);
  assign pc        = pc_q;
  assign instr_cnt = cnt_q;

endmodule
